// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot and
// auto-reload modes and a maskable registered interrupt.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             irq_q;

    logic ctrl_wr;
    logic preset_wr;
    logic en;
    logic one_shot;
    logic unused_bits;

    assign ctrl_wr     = WE && (Addr[3:2] == OFF_CTRL);
    assign preset_wr   = WE && (Addr[3:2] == OFF_PRESET);
    assign en          = ctrl_q[0];
    assign one_shot    = (ctrl_q[2:1] == 2'b00);
    assign unused_bits = ^{Addr[31:4], Addr[1:0], Din};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= ctrl_q[3] & flag_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (one_shot) begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    flag_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Bus writes override the FSM's own CTRL/flag updates.
        if (ctrl_wr) begin
            ctrl_d = Din[3:0];
            flag_d = 1'b0;
        end
        if (preset_wr) preset_d = Din[CNT_W-1:0];
    end

    always_comb begin
        Dout = '0;
        unique case (Addr[3:2])
            OFF_CTRL:   Dout = {28'd0, ctrl_q};
            OFF_PRESET: Dout = 32'(preset_q);
            OFF_COUNT:  Dout = 32'(count_q);
            default:    Dout = '0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed and random bus traffic against an
// edge-indexed model of the timer's countdown schedule.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    int n_tests = 0;
    int n_fail = 0;

    logic        irq_seen;
    logic [31:0] dout_seen;

    // Model: a period is a load edge plus an expiry edge computed
    // from the loaded preset; COUNT is derived from elapsed edges.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    longint      m_count;
    longint      m_base;
    bit          m_flag;
    bit          m_irq;
    bit          m_idle;
    longint      m_edge = 0;
    longint      m_load_at;
    longint      m_expire_at;

    always #5 clk = ~clk;

    timer_counter #(.CNT_W(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Addr   (Addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .IRQ    (IRQ)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl      = '0;
        m_preset    = '0;
        m_count     = 0;
        m_base      = 0;
        m_flag      = 0;
        m_irq       = 0;
        m_idle      = 1;
        m_load_at   = -1;
        m_expire_at = -1;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return 32'(m_count);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_in_int();
        return !m_idle && (m_expire_at >= m_load_at) &&
               (m_edge == m_expire_at);
    endfunction

    task automatic model_edge(input logic [1:0] off, input logic w,
                              input logic [31:0] d);
        longint     e = m_edge + 1;
        bit         cw = w && (off == 2'd0);
        bit         pw = w && (off == 2'd1);
        bit         en = m_ctrl[0];
        bit         os = (m_ctrl[2:1] == 2'b00);
        logic [3:0] ctrl_n = m_ctrl;
        bit         flag_n = m_flag;
        m_irq = m_ctrl[3] & m_flag;
        if (m_idle) begin
            if (en) begin
                m_idle    = 0;
                m_load_at = e + 1;
            end
        end else if (e == m_load_at) begin
            m_base      = m_preset;
            m_count     = m_base;
            m_expire_at = e + ((m_base > 1) ? m_base : 1);
        end else if (e <= m_expire_at) begin
            if (!en) begin
                m_idle      = 1;
                m_expire_at = -1;
            end else if (e == m_expire_at) begin
                m_count = 0;
                flag_n  = 1;
            end else begin
                m_count = m_base - (e - m_load_at);
            end
        end else begin
            if (os) begin
                ctrl_n[0] = 1'b0;
                m_idle    = 1;
            end else begin
                flag_n    = 0;
                m_load_at = e + 1;
            end
        end
        if (cw) begin
            ctrl_n = d[3:0];
            flag_n = 0;
        end
        if (pw) m_preset = d;
        m_ctrl = ctrl_n;
        m_flag = flag_n;
        m_edge = e;
    endtask

    task automatic tick(input logic [1:0] off, input logic w,
                        input logic [31:0] d);
        logic [31:0] r;
        r = $urandom;
        Addr = {r[31:4], off, r[1:0]};
        WE   = w;
        Din  = d;
        #1;
        check("dout", Dout, m_read(off));
        check("irq", {31'd0, IRQ}, {31'd0, m_irq});
        irq_seen  = IRQ;
        dout_seen = Dout;
        @(posedge clk);
        model_edge(off, w, d);
        #1;
    endtask

    task automatic peek(input logic [1:0] off, output logic [31:0] v);
        Addr = {28'd0, off, 2'b00};
        WE   = 1'b0;
        #1;
        v = Dout;
    endtask

    task automatic do_reset(input int cycles, input bit chk_async);
        reset_n = 1'b0;
        WE      = 1'b0;
        model_reset();
        if (chk_async) begin
            for (int o = 0; o < 4; o++) begin
                Addr = 32'(o) << 2;
                #1;
                check("rst_async_dout", Dout, 32'd0);
            end
            check("rst_async_irq", {31'd0, IRQ}, 32'd0);
        end
        repeat (cycles) @(posedge clk);
        #1;
        for (int o = 0; o < 4; o++) begin
            Addr = 32'(o) << 2;
            #1;
            check("rst_hold_dout", Dout, 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("rst_rel_irq", {31'd0, IRQ}, 32'd0);
    endtask

    task automatic run_until_count(input longint c);
        int budget = 40;
        while (m_count != c && budget > 0) begin
            tick(2'd2, 1'b0, 32'd0);
            budget--;
        end
        if (m_count != c) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_count: count %0d never reached %0d",
                     m_count, c);
        end
    endtask

    task automatic run_until_int();
        int budget = 40;
        while (!m_in_int() && budget > 0) begin
            tick(2'd2, 1'b0, 32'd0);
            budget--;
        end
        if (!m_in_int()) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_int: expiry state never reached");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        longint      pulses[$];
        bit          seen7;
        logic [31:0] r;
        int          sel;

        do_reset(2, 1'b0);
        for (int o = 0; o < 4; o++) tick(2'(o), 1'b0, 32'd0);

        // One-shot
        tick(2'd1, 1'b1, 32'd3);
        tick(2'd0, 1'b1, 32'h9);
        repeat (8) tick(2'd2, 1'b0, 32'd0);
        peek(2'd0, v);
        check("os_ctrl", v, 32'h8);
        check("os_irq_held", {31'd0, IRQ}, 32'd1);
        tick(2'd0, 1'b1, 32'h8);
        tick(2'd2, 1'b0, 32'd0);
        tick(2'd2, 1'b0, 32'd0);
        check("os_irq_clr", {31'd0, IRQ}, 32'd0);

        // Auto-reload
        tick(2'd1, 1'b1, 32'd2);
        tick(2'd0, 1'b1, 32'hB);
        for (int i = 0; i < 26; i++) begin
            tick(2'd2, 1'b0, 32'd0);
            if (irq_seen === 1'b1) pulses.push_back(i);
        end
        check("ar_npulse", 32'(pulses.size() >= 5), 32'd1);
        for (int i = 1; i < pulses.size(); i++)
            check("ar_gap", 32'(pulses[i] - pulses[i-1]), 32'd4);
        tick(2'd0, 1'b1, 32'h0);
        repeat (6) tick(2'd2, 1'b0, 32'd0);

        // Masked
        tick(2'd1, 1'b1, 32'd4);
        tick(2'd0, 1'b1, 32'h1);
        repeat (10) tick(2'd2, 1'b0, 32'd0);
        peek(2'd2, v);
        check("mask_count", v, 32'd0);
        check("mask_irq", {31'd0, IRQ}, 32'd0);
        tick(2'd0, 1'b1, 32'h0);

        // Pause
        tick(2'd1, 1'b1, 32'd6);
        tick(2'd0, 1'b1, 32'h9);
        run_until_count(3);
        tick(2'd0, 1'b1, 32'h8);
        repeat (4) tick(2'd2, 1'b0, 32'd0);
        peek(2'd2, v);
        check("pause_hold", v, 32'd2);
        check("pause_irq", {31'd0, IRQ}, 32'd0);

        // Bus corners
        tick(2'd2, 1'b1, 32'hFFFF);
        peek(2'd2, v);
        check("count_ro", v, 32'd2);
        tick(2'd3, 1'b1, $urandom);
        peek(2'd3, v);
        check("off3_zero", v, 32'd0);

        // PRESET change mid-period
        tick(2'd1, 1'b1, 32'd4);
        tick(2'd0, 1'b1, 32'hB);
        repeat (3) tick(2'd2, 1'b0, 32'd0);
        tick(2'd1, 1'b1, 32'd7);
        seen7 = 0;
        for (int i = 0; i < 12; i++) begin
            tick(2'd2, 1'b0, 32'd0);
            if (dout_seen == 32'd7) seen7 = 1;
        end
        check("reload7", {31'd0, seen7}, 32'd1);
        tick(2'd0, 1'b1, 32'h0);
        repeat (6) tick(2'd2, 1'b0, 32'd0);

        // Collision: CTRL write while in the expiry state
        tick(2'd1, 1'b1, 32'd3);
        tick(2'd0, 1'b1, 32'h9);
        run_until_int();
        tick(2'd0, 1'b1, 32'h9);
        peek(2'd0, v);
        check("coll_ctrl", v, 32'h9);
        tick(2'd2, 1'b0, 32'd0);
        tick(2'd2, 1'b0, 32'd0);
        peek(2'd2, v);
        check("coll_reload", v, 32'd3);
        repeat (6) tick(2'd2, 1'b0, 32'd0);
        tick(2'd0, 1'b1, 32'h0);
        repeat (4) tick(2'd2, 1'b0, 32'd0);

        // Reset mid-count
        tick(2'd1, 1'b1, 32'd8);
        tick(2'd0, 1'b1, 32'h9);
        run_until_count(5);
        do_reset(2, 1'b1);
        for (int o = 0; o < 4; o++) tick(2'(o), 1'b0, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r   = $urandom;
            sel = $urandom_range(0, 99);
            if (sel < 7)
                tick(2'd0, 1'b1, {r[31:4], r[3:1], (r[5:4] != 2'b00)});
            else if (sel < 12)
                tick(2'd1, 1'b1, 32'($urandom_range(0, 6)));
            else if (sel < 15)
                tick(2'($urandom_range(2, 3)), 1'b1, r);
            else
                tick(2'($urandom_range(0, 3)), 1'b0, r);
            if ($urandom_range(0, 299) == 0) do_reset(1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
